rng_share_ctrl: RTL and testbench

- Arbitrates one shared random_generator between up to NUM_REQ game-logic requesters, such as obstacle height, gap width and spawn delay.
- Sequences the generator by pulsing its enable once per granted draw, then captures the fresh value and returns it to the winner with a one-cycle grant/valid pulse.
- Enforces a per-game-tick draw budget so one frame cannot drain the sequence.
- Sits between the game FSMs and random_generator, in the game clock domain.

---
 rtl/rng_share_ctrl.sv | 139 +++++++++++++
 tb/tb_rng_share_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: round-robin arbiter that shares one random_generator among
// NUM_REQ requesters, steps it once per granted draw and returns the fresh
// value with a one-cycle grant/value_valid pulse. A per-game-tick budget
// limits how many draws are delivered between game_en pulses.
//
// Ports:
//   clk          rising-edge system clock
//   rst          synchronous active-high reset
//   game_en      one-cycle game tick, reloads the draw budget
//   req          level request per requester (bit 0 = requester 0)
//   rng_step     one-cycle enable that advances the generator
//   rng_value    generator registered output
//   grant        one-hot, one-cycle grant to the winner
//   value        captured random value, held until the next capture
//   value_valid  one-cycle pulse coincident with grant
//   busy         high whenever the FSM is not idle
//   budget_empty high when the draw budget for this tick is used up
module rng_share_ctrl #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned MAX_DRAWS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic [NUM_REQ-1:0] req,
    output logic               rng_step,
    input  logic [WIDTH-1:0]   rng_value,
    output logic [NUM_REQ-1:0] grant,
    output logic [WIDTH-1:0]   value,
    output logic               value_valid,
    output logic               busy,
    output logic               budget_empty
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_winner;
    logic [PTR_W-1:0]   w_pick;
    logic               w_any;
    int                 w_idx;
    logic [CNT_W-1:0]   r_draws;
    logic [WIDTH-1:0]   r_value;
    logic               w_deliver;
    logic               w_budget_ok;

    assign w_deliver   = (r_state == S_DELIVER);
    assign w_budget_ok = (r_draws < CNT_W'(MAX_DRAWS));

    // Round-robin search starting at rr_ptr; first set request wins.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_idx = (int'(r_rr_ptr) + i) % int'(NUM_REQ);
            if (!w_any && req[PTR_W'(w_idx)]) begin
                w_any  = 1'b1;
                w_pick = PTR_W'(w_idx);
            end
        end
    end

    // Next-state and outputs decoded from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        rng_step    = 1'b0;
        grant       = '0;
        value_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any && w_budget_ok) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                rng_step    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_DELIVER;
            end
            S_DELIVER: begin
                grant[r_winner] = 1'b1;
                value_valid     = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy         = (r_state != S_IDLE);
    assign budget_empty = (r_draws == CNT_W'(MAX_DRAWS));
    assign value        = r_value;

    // State, winner latch, value capture, round-robin pointer and budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_draws  <= '0;
            r_value  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_state_nxt == S_STEP) begin
                r_winner <= w_pick;
            end
            // Generator updated on the STEP edge, so its output is fresh here.
            if (r_state == S_WAIT) begin
                r_value <= rng_value;
            end
            if (w_deliver) begin
                r_rr_ptr <= (r_winner == PTR_W'(NUM_REQ - 1)) ? '0
                                                              : r_winner + PTR_W'(1);
            end
            // A delivery in the same cycle as game_en counts against the new tick.
            if (game_en) begin
                r_draws <= w_deliver ? CNT_W'(1) : '0;
            end else if (w_deliver && w_budget_ok) begin
                r_draws <= r_draws + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench for rng_share_ctrl with a behavioural generator that starts
// at 50 on reset and advances by one per rng_step, wrapping 175 -> 50.
module tb_rng_share_ctrl;

    logic       clk;
    logic       rst;
    logic       game_en;
    logic [2:0] req;
    logic       rng_step;
    logic [9:0] rng_value;
    logic [2:0] grant;
    logic [9:0] value;
    logic       value_valid;
    logic       busy;
    logic       budget_empty;

    int n_checks;
    int n_errors;

    rng_share_ctrl #(
        .NUM_REQ  (3),
        .WIDTH    (10),
        .MAX_DRAWS(2)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .game_en     (game_en),
        .req         (req),
        .rng_step    (rng_step),
        .rng_value   (rng_value),
        .grant       (grant),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .budget_empty(budget_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generator stand-in (MIN 50, MAX 175), reset alongside the DUT.
    always @(posedge clk) begin
        if (rst) begin
            rng_value <= 10'd50;
        end else if (rng_step) begin
            rng_value <= (rng_value == 10'd175) ? 10'd50 : rng_value + 10'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with req already driven; ends in the next IDLE cycle.
    // ge_at: 0 none, 1 game_en during STEP, 2 game_en during DELIVER.
    // req_mode: 0 hold, 1 clear on grant, 2 clear after one cycle.
    task automatic do_draw(input logic [2:0] g, input int v, input int ge_at,
                           input int req_mode, input logic exp_empty);
        tick();
        chk("step_pulse", 32'(rng_step), 32'd1);
        chk("busy_step", 32'(busy), 32'd1);
        chk("grant_step", 32'(grant), 32'd0);
        if (req_mode == 2) req = 3'b000;
        if (ge_at == 1) game_en = 1'b1;
        tick();
        game_en = 1'b0;
        chk("step_wait", 32'(rng_step), 32'd0);
        chk("valid_wait", 32'(value_valid), 32'd0);
        tick();
        chk("grant", 32'(grant), 32'(g));
        chk("valid", 32'(value_valid), 32'd1);
        chk("value", 32'(value), 32'(v));
        chk("busy_deliver", 32'(busy), 32'd1);
        if (ge_at == 2) game_en = 1'b1;
        if (req_mode == 1) req = 3'b000;
        tick();
        game_en = 1'b0;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("grant_idle", 32'(grant), 32'd0);
        chk("valid_idle", 32'(value_valid), 32'd0);
        chk("value_hold", 32'(value), 32'(v));
        chk("budget_empty", 32'(budget_empty), 32'(exp_empty));
    endtask

    task automatic pulse_game_en();
        game_en = 1'b1;
        tick();
        game_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        game_en  = 1'b0;
        req      = 3'b000;
        repeat (3) tick();
        chk("rst_step", 32'(rng_step), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(value_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(budget_empty), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        rst = 1'b0;
        tick();

        // Single and second draw from requester 0.
        req = 3'b001;
        do_draw(3'b001, 51, 0, 1, 1'b0);
        req = 3'b001;
        do_draw(3'b001, 52, 0, 1, 1'b1);

        // Budget exhausted: request stays pending, generator untouched.
        req = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_no_step", 32'(rng_step), 32'd0);
            chk("empty_idle", 32'(busy), 32'd0);
        end
        pulse_game_en();
        chk("reload_empty", 32'(budget_empty), 32'd0);
        chk("reload_idle", 32'(busy), 32'd0);
        do_draw(3'b001, 53, 0, 1, 1'b0);

        // Round robin with all requesting (rr_ptr = 1 here).
        req = 3'b111;
        do_draw(3'b010, 54, 1, 0, 1'b0);
        do_draw(3'b100, 55, 1, 0, 1'b0);
        do_draw(3'b001, 56, 1, 0, 1'b0);
        req = 3'b101;
        do_draw(3'b100, 57, 1, 0, 1'b0);
        do_draw(3'b001, 58, 1, 1, 1'b0);

        // Budget with req=011 held and no game_en: exactly two grants.
        pulse_game_en();
        chk("budget_reset", 32'(budget_empty), 32'd0);
        req = 3'b011;
        do_draw(3'b010, 59, 0, 0, 1'b0);
        do_draw(3'b001, 60, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_no_step", 32'(rng_step), 32'd0);
            chk("held_empty", 32'(budget_empty), 32'd1);
        end
        pulse_game_en();
        chk("restart_empty", 32'(budget_empty), 32'd0);
        do_draw(3'b010, 61, 0, 0, 1'b0);
        // game_en with DELIVER leaves draws_used at 1: one more draw fills it.
        do_draw(3'b001, 62, 2, 0, 1'b0);
        do_draw(3'b010, 63, 0, 1, 1'b1);

        // Winner drops req after one cycle: still granted, no second draw.
        pulse_game_en();
        req = 3'b010;
        do_draw(3'b010, 64, 0, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop_no_step", 32'(rng_step), 32'd0);
            chk("drop_idle", 32'(busy), 32'd0);
        end

        // Reset asserted while in WAIT aborts the draw.
        req = 3'b001;
        tick();
        chk("abort_step", 32'(rng_step), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_valid", 32'(value_valid), 32'd0);
        chk("abort_value", 32'(value), 32'd0);
        chk("abort_step_off", 32'(rng_step), 32'd0);
        tick();
        chk("abort_no_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        req = 3'b000;
        tick();
        chk("post_rst_value", 32'(value), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        req = 3'b001;
        do_draw(3'b001, 51, 0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
